lsu_split: RTL and testbench

Parametrised load/store unit sitting between the core's execute stage and the data memory. It replaces the combinational byte-lane logic used so far with a registered, handshaked unit. It supports 32- or 64-bit data paths, memories with wait states, and misaligned accesses that cross a word boundary. A misaligned access is either split into two memory beats or reported as a fault.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 35 +++
 rtl/lsu_split.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_split.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the byte-enable mask helper used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Lane mask spanning two consecutive beats: bits [nb-1:0] are the lanes of
    // beat 0, bits [2*nb-1:nb] the lanes of beat 1.
    function automatic logic [15:0] be_mask(input logic [1:0] size,
                                            input logic [2:0] off,
                                            input int         nb);
        logic [15:0] ones;
        logic [15:0] lanes;
        ones  = 16'((32'h1 << (32'h1 << size)) - 32'h1);
        lanes = 16'((32'h1 << (2 * nb)) - 32'h1);
        return (ones << off) & lanes;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data extractor: shifts the two captured beats down to the access offset
// and sign- or zero-extends the selected bytes to the full data width.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2*XLEN-1:0] beats,
    input  logic [OFFW-1:0]   off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   rdata
);

    localparam int IDXW = $clog2(2 * XLEN);

    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   mask;
    logic              sign;
    int                nbits;

    always_comb begin
        shifted = beats >> {off, 3'b000};
        nbits   = 8 << size;
        mask    = '1;
        if (nbits < XLEN) begin
            mask = (XLEN'(1) << nbits) - XLEN'(1);
        end
        sign  = shifted[IDXW'(nbits - 1)];
        rdata = (shifted[XLEN-1:0] & mask) | ((sign && !is_unsigned) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu_split.sv
// Registered load/store unit: accepts one core request at a time, issues one or
// two aligned memory beats and returns a single-cycle completion response.
module lsu_split
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e        state_q, state_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              cross_q, cross_d;
    logic [NB-1:0]     be1_q, be1_d;
    logic [XLEN-1:0]   wdata1_q, wdata1_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;

    logic [OFFW-1:0]   req_off;
    int                req_bytes;
    logic              req_cross;
    logic              req_fault;
    logic [ADDR_W-1:0] req_base;
    logic [2*NB-1:0]   req_be;
    logic [2*XLEN-1:0] req_wshift;

    logic [XLEN-1:0]   beat0_src;
    logic [XLEN-1:0]   beat1_src;
    logic [XLEN-1:0]   load_data;

    always_comb begin
        req_off    = req_addr[OFFW-1:0];
        req_bytes  = 1 << req_size;
        req_cross  = (int'(req_off) + req_bytes) > NB;
        req_fault  = ((req_size == SZ_D) && (XLEN == 32)) || (req_cross && !SPLIT_MISALIGNED);
        req_base   = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        req_be     = (2*NB)'(be_mask(req_size, 3'(req_off), NB));
        req_wshift = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    end

    // The beat being accepted this cycle bypasses the capture register so the
    // response can be registered on the same edge that completes the beat.
    always_comb begin
        beat0_src = (state_q == BEAT0) ? mem_rdata : beat0_q;
        beat1_src = (state_q == BEAT1) ? mem_rdata : '0;
    end

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .beats      ({beat1_src, beat0_src}),
        .off        (off_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .rdata      (load_data)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cross_d     = cross_q;
        be1_d       = be1_q;
        wdata1_d    = wdata1_q;
        beat0_d     = beat0_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_off;
                    cross_d     = req_cross;
                    be1_d       = req_be[2*NB-1:NB];
                    wdata1_d    = req_wshift[2*XLEN-1:XLEN];
                    if (req_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = req_base;
                        mem_we_d    = req_we;
                        mem_be_d    = req_be[NB-1:0];
                        mem_wdata_d = req_wshift[XLEN-1:0];
                    end
                end
            end

            BEAT0: begin
                if (mem_ready) begin
                    beat0_d = mem_rdata;
                    if (cross_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(NB);
                        mem_be_d    = be1_q;
                        mem_wdata_d = wdata1_q;
                    end else begin
                        state_d     = RESP;
                        mem_valid_d = 1'b0;
                        mem_addr_d  = '0;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '0;
                        mem_wdata_d = '0;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b0;
                        rsp_rdata_d = we_q ? '0 : load_data;
                    end
                end
            end

            BEAT1: begin
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = we_q ? '0 : load_data;
                end
            end

            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_fault_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            cross_q     <= 1'b0;
            be1_q       <= '0;
            wdata1_q    <= '0;
            beat0_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cross_q     <= cross_d;
            be1_q       <= be1_d;
            wdata1_q    <= wdata1_d;
            beat0_q     <= beat0_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split: one splitting instance driven by a memory
// model, one faulting instance whose memory port must stay idle.
module tb_lsu_split;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_ns, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_ready_ns;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_ready, rsp_valid, rsp_fault, mem_valid, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        req_ready_ns, rsp_valid_ns, rsp_fault_ns, mem_valid_ns, mem_we_ns;
    logic [31:0] rsp_rdata_ns, mem_addr_ns, mem_wdata_ns;
    logic [3:0]  mem_be_ns;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
        int          cycle;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    rsp_t  exp_rsp[$];
    rsp_t  exp_rsp_ns[$];
    beat_t exp_beats[$];

    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    bit    ns_beat_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    lsu_split #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_split #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns), .rsp_fault(rsp_fault_ns),
        .mem_valid(mem_valid_ns), .mem_ready(mem_ready_ns), .mem_addr(mem_addr_ns),
        .mem_we(mem_we_ns), .mem_be(mem_be_ns), .mem_wdata(mem_wdata_ns), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushBeat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        beat_t b;
        b.addr  = addr;
        b.be    = be;
        b.we    = we;
        b.wdata = wdata;
        b.rdata = rdata;
        b.waits = waits;
        exp_beats.push_back(b);
    endtask

    // Expected response cycle: counted from the negedge where the request is
    // driven, so latency 1 means visible right after the accepting edge.
    task automatic applyStimulus(input bit ns, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input string tag, input logic [31:0] exp_rdata,
                                 input logic exp_fault, input int latency);
        rsp_t r;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!(ns ? req_ready_ns : req_ready) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!(ns ? req_ready_ns : req_ready)) checkOutput({tag, "_req_ready_timeout"}, 0, 1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        r.tag   = tag;
        r.rdata = exp_rdata;
        r.fault = exp_fault;
        r.cycle = cyc + latency;
        if (ns) begin
            req_valid_ns = 1'b1;
            exp_rsp_ns.push_back(r);
        end else begin
            req_valid = 1'b1;
            exp_rsp.push_back(r);
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_rsp_ns.size() != 0 || exp_beats.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_rsp.size() != 0 || exp_rsp_ns.size() != 0 || exp_beats.size() != 0)
            checkOutput("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Memory model: checks each beat as it first appears, checks it is held
    // during wait cycles and accepts it after the programmed wait count.
    beat_t cur;
    bit    busy = 1'b0;
    int    wait_left = 0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBADBAD00;
        if (!reset || !mem_valid) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                if (exp_beats.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    cur       = exp_beats.pop_front();
                    busy      = 1'b1;
                    wait_left = cur.waits;
                    checkOutput("beat_addr", mem_addr, cur.addr);
                    checkOutput("beat_be", mem_be, cur.be);
                    checkOutput("beat_we", mem_we, cur.we);
                    checkOutput("beat_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                checkOutput("beat_hold", {mem_addr, mem_be, mem_we, mem_wdata},
                            {cur.addr, cur.be, cur.we, cur.wdata});
            end
            if (busy) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata;
                    busy      = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_valid_ns) ns_beat_seen = 1'b1;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                checkOutput("unexpected_rsp", 1, 0);
            end else begin
                e = exp_rsp.pop_front();
                checkOutput({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                checkOutput({e.tag, "_fault"}, rsp_fault, e.fault);
                checkOutput({e.tag, "_cycle"}, cyc, e.cycle);
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid_ns) begin
            if (exp_rsp_ns.size() == 0) begin
                checkOutput("unexpected_rsp_ns", 1, 0);
            end else begin
                e = exp_rsp_ns.pop_front();
                checkOutput({e.tag, "_rdata"}, rsp_rdata_ns, e.rdata);
                checkOutput({e.tag, "_fault"}, rsp_fault_ns, e.fault);
                checkOutput({e.tag, "_cycle"}, cyc, e.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ready_ns = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {req_ready, rsp_valid, rsp_fault, rsp_rdata, mem_valid,
                                      mem_we, mem_be, mem_addr, mem_wdata}, '0);
        checkOutput("reset_outputs_ns", {req_ready_ns, rsp_valid_ns, rsp_fault_ns, rsp_rdata_ns,
                                         mem_valid_ns, mem_we_ns, mem_be_ns, mem_addr_ns,
                                         mem_wdata_ns}, '0);
        #2 reset = 1'b1;
        checkOutput("ready_low_after_release", req_ready, 0);
        @(negedge clk);
        checkOutput("ready_first_clock", req_ready, 1);

        pushBeat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "lw_aligned", 32'hDEADBEEF, 1'b0, 2);
        waitIdle();

        pushBeat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FF0000, 0);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, "lb", 32'hFFFFFF80, 1'b0, 2);
        waitIdle();

        pushBeat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FF0000, 0);
        applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, "lbu", 32'h00000080, 1'b0, 2);
        waitIdle();

        pushBeat(32'h100, 4'b1100, 1'b1, 32'hABCD0000, 32'h12345678, 0);
        applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, "sh", 32'h0, 1'b0, 2);
        waitIdle();

        pushBeat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 0);
        applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, "lh", 32'hFFFF8001, 1'b0, 2);
        waitIdle();

        pushBeat(32'h0FC, 4'b1100, 1'b0, 32'h0, 32'h33440000, 0);
        pushBeat(32'h100, 4'b0011, 1'b0, 32'h0, 32'h00001122, 0);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, "lw_split", 32'h11223344, 1'b0, 3);
        waitIdle();

        pushBeat(32'h100, 4'b1000, 1'b0, 32'h0, 32'hAA000000, 0);
        pushBeat(32'h104, 4'b0001, 1'b0, 32'h0, 32'h000000BB, 0);
        applyStimulus(0, 1'b0, 2'd1, 1'b1, 32'h103, 32'h0, "lhu_split", 32'h0000BBAA, 1'b0, 3);
        waitIdle();

        pushBeat(32'hFFFFFFFC, 4'b1000, 1'b1, 32'hD4000000, 32'h0, 0);
        pushBeat(32'h00000000, 4'b0111, 1'b1, 32'h00A1B2C3, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'hA1B2C3D4, "sw_wrap", 32'h0, 1'b0, 3);
        waitIdle();

        // A dword on the 32-bit unit is an illegal size: fault, no beat.
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 32'h200, 32'h0, "ld_illegal", 32'h0, 1'b1, 1);
        waitIdle();

        applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, "lw_fault_ns", 32'h0, 1'b1, 1);
        waitIdle();
        checkOutput("ns_no_beat", ns_beat_seen, 0);

        pushBeat(32'h104, 4'b1111, 1'b1, 32'h55667788, 32'h0, 3);
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h104, 32'h55667788, "sw_wait", 32'h0, 1'b0, 5);
        waitIdle();

        pushBeat(32'h0FC, 4'b1100, 1'b0, 32'h0, 32'h33440000, 0);
        pushBeat(32'h100, 4'b0011, 1'b0, 32'h0, 32'h00001122, 10);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, "lw_reset", 32'h0, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("beat1_before_reset", {mem_valid, mem_addr}, {1'b1, 32'h100});
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_mem_valid", mem_valid, 0);
        checkOutput("reset_mid_rsp_valid", rsp_valid, 0);
        // The interrupted request never completes, so its response is dropped.
        exp_rsp.delete();
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_ready_after", req_ready, 1);
        repeat (5) @(negedge clk);

        pushBeat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 0);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "lw_after_reset", 32'hCAFEF00D, 1'b0, 2);
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
